matmul_seq: RTL
===============

Name: matmul_seq

Overview:
- Sequential, handshaked successor to the combinational int8 vector-matrix multiply used in the NNUE linear layers.
- Computes out[j] = sum over i of x[i]*w[i][j] for an N-element int8 input vector and an N×P int8 weight matrix.
- Processes one input row per cycle, so all P accumulators update in parallel.
- Adds a runtime output mode: wrap, saturate, or NNUE clipped ReLU. This lets the same block feed either a following linear layer or the activation stage.

Parameters:
- N, 2, input vector length (rows of W); N >= 1.
- P, 3, output vector length (columns of W); P >= 1.
- OUT_W, 16, width of each output element; 8 <= OUT_W <= 32.
- SHIFT, 6, right arithmetic shift applied before clamping in clipped-ReLU mode.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  x, w and mode are valid.
- in_ready  out  1  block can accept an operand set.
- x  in  [0:N*8-1]  signed int8 x[i] at bits [i*8 +: 8].
- w  in  [0:N*P*8-1]  signed int8 w[i][j] at bits [(i*P+j)*8 +: 8].
- mode  in  2  0 = wrap, 1 = saturate, 2 = clipped ReLU, 3 = treated as 0.
- out_valid  out  1  out holds a finished result.
- out_ready  in  1  consumer accepts the result.
- out  out  [0:P*OUT_W-1]  element j at bits [j*OUT_W +: OUT_W].

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, out=0, accumulators=0, row counter=0.
- rst has priority over every other input, including mid-ACC and mid-DONE. The block returns to IDLE on the next edge and discards any partial result.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid & in_ready at an edge.
  - On accept: latch x, w and mode into internal registers, clear accumulators, set row counter k=0, go to ACC.
- ACC:
  - in_ready=0.
  - Each edge: acc[j] += sext(x[k]*w[k][j]) for all j, then k++.
  - After the edge that processes k=N-1, go to DONE and register the formatted out.
  - Exactly N cycles are spent in ACC. Inputs changing during ACC have no effect.
- DONE:
  - out_valid=1, in_ready=0.
  - out and out_valid stay stable until out_ready=1 at an edge.
  - On that edge: out_valid drops to 0 and the state goes to IDLE. out holds its last value.
- Latency: with the accept on edge e, out_valid is high after edge e+N.
- Throughput, with out_ready tied high: one result every N+2 cycles.
- Arithmetic:
  - Each product is a 16-bit signed value.
  - Accumulators are signed, width 16+clog2(N)+1, so no internal overflow is possible.
- Output formatting, using the mode latched at accept:
  - mode 0: low OUT_W bits of acc (two's-complement wrap).
  - mode 1: clamp acc to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - mode 2: clamp(acc >>> SHIFT, 0, 127), zero-extended to OUT_W.
- N=1 is legal: exactly one ACC cycle.

Test Plan:
- N=2, P=3, mode 0, x=[1,2], w=[[1,2,3],[4,5,6]], out_ready=1 -> out=[9,12,15]; out_valid rises 2 edges after the accept edge and lasts 1 cycle.
- x=[-128,-128], all w=-128, OUT_W=16 -> mode 0 out=[-32768]*3; mode 1 out=[32767]*3; mode 2 (SHIFT=6) out=[127]*3.
- mode 2, x=[1,0], w row0=[-5,64,300→clipped N/A: use 100], row1 arbitrary -> out=[0,1,1] (-5>>>6=-1 clamps to 0; 64>>>6=1; 100>>>6=1).
- Backpressure: result ready, out_ready low for 5 cycles -> out_valid=1 and out unchanged throughout, in_ready=0, and a new in_valid is not accepted; out_ready=1 -> IDLE next edge.
- rst=1 for one cycle during ACC (after k=0) -> next cycle IDLE, in_ready=1, out_valid=0. A new operation then produces a correct result with no residue from the aborted one.
- in_valid held high with 4 different operand sets, out_ready=1 -> 4 correct results in order, spaced exactly N+2 cycles apart; changing mode between sets takes effect only per accepted set.

Source files
------------

// File: rtl/matmul_seq.sv
// matmul_seq: handshaked int8 vector-matrix multiply, out[j] = sum_i x[i]*w[i][j].
// One input row is folded into all P accumulators per cycle, so a result takes
// N cycles in ACC. The finished accumulators are formatted by the mode latched
// at accept: two's-complement wrap, signed saturation, or NNUE clipped ReLU.
module matmul_seq #(
  parameter int unsigned N     = 2,
  parameter int unsigned P     = 3,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:N*8-1]       x,
  input  logic [0:N*P*8-1]     w,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:P*OUT_W-1]   out
);

  // Accumulator headroom: N products of at most 2^14 magnitude can never overflow.
  localparam int unsigned AccW = 16 + $clog2(N) + 1;
  localparam int unsigned KW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] ModeWrap = 2'd0;
  localparam logic [1:0] ModeSat  = 2'd1;
  localparam logic [1:0] ModeRelu = 2'd2;

  localparam logic signed [63:0] SatMax = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam logic signed [63:0] SatMin = -(64'sd1 <<< (OUT_W - 1));

  logic [1:0]             state_q, state_d;
  logic signed [7:0]      x_q [N];
  logic signed [7:0]      x_d [N];
  logic signed [7:0]      w_q [N][P];
  logic signed [7:0]      w_d [N][P];
  logic [1:0]             mode_q, mode_d;
  logic [KW-1:0]          k_q, k_d;
  logic signed [AccW-1:0] acc_q [P];
  logic signed [AccW-1:0] acc_d [P];
  logic [0:P*OUT_W-1]     out_q, out_d;

  logic signed [15:0]     prod [P];
  logic signed [AccW-1:0] acc_sum [P];
  logic signed [63:0]     acc_ext [P];
  logic signed [63:0]     acc_shr [P];
  logic [OUT_W-1:0]       fmt [P];

  // Row-k products added to every column accumulator in parallel.
  always_comb begin
    for (int j = 0; j < P; j++) begin
      prod[j]    = x_q[k_q] * w_q[k_q][j];
      acc_sum[j] = acc_q[j] + {{(AccW - 16){prod[j][15]}}, prod[j]};
    end
  end

  // Format the post-update accumulators so the last ACC edge can register them.
  always_comb begin
    for (int j = 0; j < P; j++) begin
      acc_ext[j] = {{(64 - AccW){acc_sum[j][AccW-1]}}, acc_sum[j]};
      acc_shr[j] = acc_ext[j] >>> SHIFT;
      fmt[j]     = acc_ext[j][OUT_W-1:0];
      case (mode_q)
        ModeSat: begin
          if (acc_ext[j] > SatMax) begin
            fmt[j] = SatMax[OUT_W-1:0];
          end else if (acc_ext[j] < SatMin) begin
            fmt[j] = SatMin[OUT_W-1:0];
          end
        end
        ModeRelu: begin
          if (acc_shr[j] < 64'sd0) begin
            fmt[j] = '0;
          end else if (acc_shr[j] > 64'sd127) begin
            fmt[j] = {{(OUT_W - 7){1'b0}}, 7'd127};
          end else begin
            fmt[j] = {{(OUT_W - 7){1'b0}}, acc_shr[j][6:0]};
          end
        end
        // Wrap, and the unused encoding 3 behaves as wrap.
        default: fmt[j] = acc_ext[j][OUT_W-1:0];
      endcase
    end
  end

  // FSM next state: latch operands on accept, accumulate N rows, hold until taken.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    w_d     = w_q;
    mode_d  = mode_q;
    k_d     = k_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          for (int i = 0; i < N; i++) begin
            x_d[i] = x[i*8 +: 8];
            for (int j = 0; j < P; j++) begin
              w_d[i][j] = w[(i*P + j)*8 +: 8];
            end
          end
          mode_d = mode;
          k_d    = '0;
          for (int j = 0; j < P; j++) begin
            acc_d[j] = '0;
          end
          state_d = StAcc;
        end
      end
      StAcc: begin
        acc_d = acc_sum;
        if (k_q == KW'(N - 1)) begin
          k_d     = '0;
          state_d = StDone;
          for (int j = 0; j < P; j++) begin
            out_d[j*OUT_W +: OUT_W] = fmt[j];
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: begin
        // out is deliberately left holding the last result after the handoff.
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; rst aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= ModeWrap;
      k_q     <= '0;
      out_q   <= '0;
      for (int i = 0; i < N; i++) begin
        x_q[i] <= '0;
        for (int j = 0; j < P; j++) begin
          w_q[i][j] <= '0;
        end
      end
      for (int j = 0; j < P; j++) begin
        acc_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      out_q   <= out_d;
      x_q     <= x_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out       = out_q;
  end

endmodule
